l2_home_stub: RTL

- Home-node responder on the far end of the L2 coherence channels.
- Consumes the L2's outgoing requests (GetS/GetM/PutS/PutM) and answers them:
  - Data/EData on the L2's response-in channel.
  - PutAck on the L2's forward-in channel.
- Holds a small line store with per-line owned tracking.
- Used as a single-L2 home model for block-level L2 bring-up and as the basis of a minimal LLC front end.

---
 rtl/l2_home_stub_pkg.sv | 32 +++
 rtl/l2_home_stub_mem.sv | 67 ++++++
 rtl/l2_home_stub.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/l2_home_stub_pkg.sv
// rtl/l2_home_stub_pkg.sv - shared L2 coherence message encodings and home-stub FSM states
package l2_home_stub_pkg;

   localparam int COH_MSG_BITS = 2;
   localparam int INVACK_BITS  = 4;
   localparam int HPROT_BITS   = 2;

   // Requests travelling from the L2 towards the home node
   localparam logic [COH_MSG_BITS-1:0] REQ_GETS = 2'd0;
   localparam logic [COH_MSG_BITS-1:0] REQ_GETM = 2'd1;
   localparam logic [COH_MSG_BITS-1:0] REQ_PUTS = 2'd2;
   localparam logic [COH_MSG_BITS-1:0] REQ_PUTM = 2'd3;

   // Responses delivered on the L2 response-in channel
   localparam logic [COH_MSG_BITS-1:0] RSP_DATA  = 2'd0;
   localparam logic [COH_MSG_BITS-1:0] RSP_EDATA = 2'd1;

   // Forwards delivered on the L2 forward-in channel
   localparam logic [COH_MSG_BITS-1:0] FWD_PUTACK = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_SEND = 2'd2
   } home_state_t;

   // True for the two request types that hand ownership to the L2
   function automatic logic is_get(input logic [COH_MSG_BITS-1:0] msg);
      return (msg == REQ_GETS) || (msg == REQ_GETM);
   endfunction

endpackage

// File: rtl/l2_home_stub_mem.sv
// rtl/l2_home_stub_mem.sv - line store with valid/owned tracking for the L2 home stub
module l2_home_stub_mem
   import l2_home_stub_pkg::*;
#(
   parameter int ADDR_BITS = 26,
   parameter int LINE_BITS = 128,
   parameter int WORD_BITS = 32,
   parameter int MEM_LINES = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic                 wr_en,
   input  logic [LINE_BITS-1:0] wr_line,
   input  logic                 set_owned,
   input  logic                 clr_owned,
   output logic [LINE_BITS-1:0] rd_line,
   output logic                 rd_owned
);

   localparam int IDX_BITS = $clog2(MEM_LINES);
   localparam int WORDS    = LINE_BITS / WORD_BITS;

   logic [LINE_BITS-1:0] lines [MEM_LINES];
   logic [MEM_LINES-1:0] valid_bits;
   logic [MEM_LINES-1:0] owned_bits;
   logic [IDX_BITS-1:0]  idx;
   logic [LINE_BITS-1:0] pattern;

   assign idx = addr[IDX_BITS-1:0];

   // Lines never written read back as the line address replicated in every word
   always_comb begin
      pattern = '0;
      for (int w = 0; w < WORDS; w++) begin
         pattern[w*WORD_BITS +: WORD_BITS] = WORD_BITS'(addr);
      end
   end

   // Line data has no reset; the valid bit decides whether it is visible
   always_ff @(posedge clk) begin
      if (wr_en) begin
         lines[idx] <= wr_line;
      end
   end

   // Valid and owned tracking, cleared by reset so stale data is hidden
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_bits <= '0;
         owned_bits <= '0;
      end else begin
         if (wr_en) begin
            valid_bits[idx] <= 1'b1;
         end
         if (set_owned) begin
            owned_bits[idx] <= 1'b1;
         end else if (clr_owned) begin
            owned_bits[idx] <= 1'b0;
         end
      end
   end

   assign rd_line  = valid_bits[idx] ? lines[idx] : pattern;
   assign rd_owned = owned_bits[idx];

endmodule

// File: rtl/l2_home_stub.sv
// rtl/l2_home_stub.sv - single-L2 home responder; optional stats under L2_HOME_STUB_STATS_EN
module l2_home_stub
   import l2_home_stub_pkg::*;
#(
   parameter int ADDR_BITS = 26,
   parameter int LINE_BITS = 128,
   parameter int WORD_BITS = 32,
   parameter int MEM_LINES = 64,
   parameter int LATENCY   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    l2_req_out_valid,
   output logic                    l2_req_out_ready,
   input  logic [COH_MSG_BITS-1:0] l2_req_out_coh_msg,
   input  logic [HPROT_BITS-1:0]   l2_req_out_hprot,
   input  logic [ADDR_BITS-1:0]    l2_req_out_addr,
   input  logic [LINE_BITS-1:0]    l2_req_out_line,
   output logic                    l2_rsp_in_valid,
   input  logic                    l2_rsp_in_ready,
   output logic [COH_MSG_BITS-1:0] l2_rsp_in_coh_msg,
   output logic [ADDR_BITS-1:0]    l2_rsp_in_addr,
   output logic [LINE_BITS-1:0]    l2_rsp_in_line,
   output logic [INVACK_BITS-1:0]  l2_rsp_in_invack_cnt,
   output logic                    l2_fwd_in_valid,
   input  logic                    l2_fwd_in_ready,
   output logic [COH_MSG_BITS-1:0] l2_fwd_in_coh_msg,
   output logic [ADDR_BITS-1:0]    l2_fwd_in_addr,
   output logic                    proto_err
`ifdef L2_HOME_STUB_STATS_EN
   ,
   output logic [15:0]             stat_gets,
   output logic [15:0]             stat_getm,
   output logic [15:0]             stat_puts,
   output logic [15:0]             stat_putm
`endif
);

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   home_state_t             state;
   logic [CW-1:0]           cnt;
   logic [COH_MSG_BITS-1:0] lat_msg;
   logic [ADDR_BITS-1:0]    lat_addr;
   logic [LINE_BITS-1:0]    lat_line;

   logic                    accept;
   logic                    req_get;
   logic                    violation;
   logic                    go_send;
   logic [COH_MSG_BITS-1:0] sel_msg;
   logic [ADDR_BITS-1:0]    sel_addr;
   logic [LINE_BITS-1:0]    sel_line;
   logic [LINE_BITS-1:0]    rd_line;
   logic                    rd_owned;
   logic                    unused_hprot;

   assign unused_hprot         = ^l2_req_out_hprot;
   assign l2_rsp_in_invack_cnt = '0;

   assign accept    = (state == ST_IDLE) && l2_req_out_valid && l2_req_out_ready;
   assign req_get   = is_get(l2_req_out_coh_msg);
   assign violation = accept && (req_get ? rd_owned : !rd_owned);

   // Store side effects all happen on the accept edge; the read is captured there too
   l2_home_stub_mem #(
      .ADDR_BITS (ADDR_BITS),
      .LINE_BITS (LINE_BITS),
      .WORD_BITS (WORD_BITS),
      .MEM_LINES (MEM_LINES)
   ) u_mem (
      .clk       (clk),
      .rst       (rst),
      .addr      (l2_req_out_addr),
      .wr_en     (accept && (l2_req_out_coh_msg == REQ_PUTM)),
      .wr_line   (l2_req_out_line),
      .set_owned (accept && req_get),
      .clr_owned (accept && !req_get),
      .rd_line   (rd_line),
      .rd_owned  (rd_owned)
   );

   // Pick the response source: the live request when LATENCY is zero, else the latched copy
   always_comb begin
      go_send  = 1'b0;
      sel_msg  = lat_msg;
      sel_addr = lat_addr;
      sel_line = lat_line;
      if (state == ST_IDLE) begin
         go_send  = accept && (LATENCY == 0);
         sel_msg  = l2_req_out_coh_msg;
         sel_addr = l2_req_out_addr;
         sel_line = rd_line;
      end else if (state == ST_WAIT) begin
         go_send = (cnt == '0);
      end
   end

   // Request/response FSM with registered channel outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= ST_IDLE;
         cnt               <= '0;
         lat_msg           <= '0;
         lat_addr          <= '0;
         lat_line          <= '0;
         l2_req_out_ready  <= 1'b1;
         l2_rsp_in_valid   <= 1'b0;
         l2_rsp_in_coh_msg <= '0;
         l2_rsp_in_addr    <= '0;
         l2_rsp_in_line    <= '0;
         l2_fwd_in_valid   <= 1'b0;
         l2_fwd_in_coh_msg <= '0;
         l2_fwd_in_addr    <= '0;
         proto_err         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  lat_msg          <= l2_req_out_coh_msg;
                  lat_addr         <= l2_req_out_addr;
                  lat_line         <= rd_line;
                  l2_req_out_ready <= 1'b0;
                  if (violation) begin
                     proto_err <= 1'b1;
                  end
                  if (LATENCY == 0) begin
                     state <= ST_SEND;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= (LATENCY > 0) ? CW'(LATENCY - 1) : '0;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  state <= ST_SEND;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_SEND: begin
               if ((l2_rsp_in_valid && l2_rsp_in_ready) ||
                   (l2_fwd_in_valid && l2_fwd_in_ready)) begin
                  state            <= ST_IDLE;
                  l2_rsp_in_valid  <= 1'b0;
                  l2_fwd_in_valid  <= 1'b0;
                  l2_req_out_ready <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase

         if (go_send) begin
            if (is_get(sel_msg)) begin
               l2_rsp_in_valid   <= 1'b1;
               l2_rsp_in_coh_msg <= (sel_msg == REQ_GETS) ? RSP_EDATA : RSP_DATA;
               l2_rsp_in_addr    <= sel_addr;
               l2_rsp_in_line    <= sel_line;
            end else begin
               l2_fwd_in_valid   <= 1'b1;
               l2_fwd_in_coh_msg <= FWD_PUTACK;
               l2_fwd_in_addr    <= sel_addr;
            end
         end
      end
   end

`ifdef L2_HOME_STUB_STATS_EN
   // Saturating per-type counters of accepted requests
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_gets <= '0;
         stat_getm <= '0;
         stat_puts <= '0;
         stat_putm <= '0;
      end else if (accept) begin
         case (l2_req_out_coh_msg)
            REQ_GETS: if (stat_gets != 16'hFFFF) stat_gets <= stat_gets + 16'd1;
            REQ_GETM: if (stat_getm != 16'hFFFF) stat_getm <= stat_getm + 16'd1;
            REQ_PUTS: if (stat_puts != 16'hFFFF) stat_puts <= stat_puts + 16'd1;
            default:  if (stat_putm != 16'hFFFF) stat_putm <= stat_putm + 16'd1;
         endcase
      end
   end
`endif

endmodule
